ex: RTL and testbench

EX -- requirements
Module: ex

---
 rtl/ex.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_ex.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex.sv
`default_nettype none
// ============================================================================
// Module  : ex
// Brief   : Execute stage. Single-cycle ALU, single-cycle multiply, HI/LO
//           registers and a 32-step restoring divider that stalls the pipe.
// Rev     : 1.0  initial release
// ============================================================================

// Opcode encodings mirror defines.v; guarded so a shared defines.v may win.
`ifndef EX_DEFINES_V
`define EX_DEFINES_V
`define AluOpBus      7:0
`define AluSelBus     2:0
`define EXE_OP_NOP    8'h00
`define EXE_OP_OR     8'h25
`define EXE_OP_AND    8'h24
`define EXE_OP_XOR    8'h26
`define EXE_OP_NOR    8'h27
`define EXE_OP_SLL    8'h7C
`define EXE_OP_SRL    8'h02
`define EXE_OP_SRA    8'h03
`define EXE_OP_ADDU   8'h21
`define EXE_OP_SUBU   8'h23
`define EXE_OP_SLT    8'h2A
`define EXE_OP_SLTU   8'h2B
`define EXE_OP_MFHI   8'h10
`define EXE_OP_MTHI   8'h11
`define EXE_OP_MFLO   8'h12
`define EXE_OP_MTLO   8'h13
`define EXE_OP_MULT   8'h18
`define EXE_OP_MULTU  8'h19
`define EXE_OP_DIV    8'h1A
`define EXE_OP_DIVU   8'h1B
`define EXE_SEL_NOP   3'd0
`define EXE_SEL_LOGIC 3'd1
`define EXE_SEL_SHIFT 3'd2
`define EXE_SEL_ARITH 3'd3
`define EXE_SEL_MOVE  3'd4
`define EXE_SEL_MUL   3'd5
`endif

module ex (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [`AluOpBus]  aluop,
  input  logic [`AluSelBus] alusel,
  input  logic [31:0]       reg0,
  input  logic [31:0]       reg1,
  input  logic [4:0]        waddr,
  input  logic              we,
  output logic [31:0]       wdata,
  output logic [4:0]        waddr_o,
  output logic              we_o,
  output logic              stallreq,
  output logic [31:0]       hi,
  output logic [31:0]       lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  div_state_t  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] w_logic, w_shift, w_arith, w_move;
  logic        w_known, w_hilo_only, w_is_div, w_busy;
  logic signed [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_abs_a, w_abs_b;
  logic [33:0] w_trial;
  logic [31:0] w_quo_fix, w_rem_fix;

  // ---------------------------------------------------------------- ALU
  always_comb begin
    w_logic = 32'd0;
    case (aluop)
      `EXE_OP_OR:  w_logic = reg0 | reg1;
      `EXE_OP_AND: w_logic = reg0 & reg1;
      `EXE_OP_XOR: w_logic = reg0 ^ reg1;
      `EXE_OP_NOR: w_logic = ~(reg0 | reg1);
      default:     w_logic = 32'd0;
    endcase
  end

  always_comb begin
    w_shift = 32'd0;
    case (aluop)
      `EXE_OP_SLL: w_shift = reg0 << reg1[4:0];
      `EXE_OP_SRL: w_shift = reg0 >> reg1[4:0];
      `EXE_OP_SRA: w_shift = $unsigned($signed(reg0) >>> reg1[4:0]);
      default:     w_shift = 32'd0;
    endcase
  end

  always_comb begin
    w_arith = 32'd0;
    case (aluop)
      `EXE_OP_ADDU: w_arith = reg0 + reg1;
      `EXE_OP_SUBU: w_arith = reg0 - reg1;
      `EXE_OP_SLT:  w_arith = {31'd0, $signed(reg0) < $signed(reg1)};
      `EXE_OP_SLTU: w_arith = {31'd0, reg0 < reg1};
      default:      w_arith = 32'd0;
    endcase
  end

  always_comb begin
    w_move = 32'd0;
    case (aluop)
      `EXE_OP_MFHI: w_move = hi_q;
      `EXE_OP_MFLO: w_move = lo_q;
      default:      w_move = 32'd0;
    endcase
  end

  always_comb begin
    wdata = 32'd0;
    case (alusel)
      `EXE_SEL_LOGIC: wdata = w_logic;
      `EXE_SEL_SHIFT: wdata = w_shift;
      `EXE_SEL_ARITH: wdata = w_arith;
      `EXE_SEL_MOVE:  wdata = w_move;
      default:        wdata = 32'd0;
    endcase
  end

  always_comb begin
    w_known     = 1'b0;
    w_hilo_only = 1'b0;
    case (aluop)
      `EXE_OP_OR, `EXE_OP_AND, `EXE_OP_XOR, `EXE_OP_NOR,
      `EXE_OP_SLL, `EXE_OP_SRL, `EXE_OP_SRA,
      `EXE_OP_ADDU, `EXE_OP_SUBU, `EXE_OP_SLT, `EXE_OP_SLTU,
      `EXE_OP_MFHI, `EXE_OP_MFLO: w_known = 1'b1;
      `EXE_OP_MULT, `EXE_OP_MULTU, `EXE_OP_DIV, `EXE_OP_DIVU,
      `EXE_OP_MTHI, `EXE_OP_MTLO: begin
        w_known     = 1'b1;
        w_hilo_only = 1'b1;
      end
      default: begin
        w_known     = 1'b0;
        w_hilo_only = 1'b0;
      end
    endcase
  end

  assign waddr_o = waddr;
  assign we_o    = we & w_known & ~w_hilo_only;

  // ---------------------------------------------------------------- multiply
  assign w_prod_s = $signed(reg0) * $signed(reg1);
  assign w_prod_u = {32'd0, reg0} * {32'd0, reg1};

  // ---------------------------------------------------------------- divider
  assign w_is_div = (aluop == `EXE_OP_DIV) || (aluop == `EXE_OP_DIVU);
  assign w_a_neg  = (aluop == `EXE_OP_DIV) & reg0[31];
  assign w_b_neg  = (aluop == `EXE_OP_DIV) & reg1[31];
  assign w_abs_a  = w_a_neg ? (32'd0 - reg0) : reg0;
  assign w_abs_b  = w_b_neg ? (32'd0 - reg1) : reg1;

  // Partial remainder shifted left with the next dividend bit, minus divisor.
  assign w_trial  = {1'b0, rem_q, quo_q[31]} - {2'b00, dvs_q};

  assign w_quo_fix = qneg_q ? (32'd0 - quo_q) : quo_q;
  assign w_rem_fix = rneg_q ? (32'd0 - rem_q) : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    w_busy  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_is_div) begin
          w_busy = 1'b1;
          cnt_d  = 6'd0;
          if (reg1 == 32'd0) begin
            // Final values stored directly, so sign correction is disabled.
            state_d = S_DONE;
            quo_d   = 32'hFFFF_FFFF;
            rem_d   = reg0;
            dvs_d   = 32'd0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
          end else begin
            state_d = S_BUSY;
            quo_d   = w_abs_a;
            rem_d   = 32'd0;
            dvs_d   = w_abs_b;
            qneg_d  = w_a_neg ^ w_b_neg;
            rneg_d  = w_a_neg;
          end
        end
      end
      S_BUSY: begin
        w_busy = 1'b1;
        cnt_d  = cnt_q + 6'd1;
        if (!w_trial[33]) begin
          rem_d = w_trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = {rem_q[30:0], quo_q[31]};
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (cnt_q == 6'd31) state_d = S_DONE;
      end
      S_DONE: begin
        if (!stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stallreq = w_busy & ~rst;

  // ---------------------------------------------------------------- HI/LO
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (!stall) begin
      if (state_q == S_DONE) begin
        hi_d = w_rem_fix;
        lo_d = w_quo_fix;
      end else if (!stallreq) begin
        case (aluop)
          `EXE_OP_MULT:  {hi_d, lo_d} = w_prod_s;
          `EXE_OP_MULTU: {hi_d, lo_d} = w_prod_u;
          `EXE_OP_MTHI:  hi_d = reg0;
          `EXE_OP_MTLO:  lo_d = reg0;
          default: begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_ex.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex
// Brief   : Randomised bench for ex against an arithmetic reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ex;

  localparam logic [7:0] OP_NOP = 8'h00, OP_OR = 8'h25, OP_AND = 8'h24,
    OP_XOR = 8'h26, OP_NOR = 8'h27, OP_SLL = 8'h7C, OP_SRL = 8'h02,
    OP_SRA = 8'h03, OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_SLT = 8'h2A,
    OP_SLTU = 8'h2B, OP_MFHI = 8'h10, OP_MTHI = 8'h11, OP_MFLO = 8'h12,
    OP_MTLO = 8'h13, OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1A,
    OP_DIVU = 8'h1B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [7:0]  aluop = OP_NOP;
  logic [2:0]  alusel = 3'd0;
  logic [31:0] reg0 = 32'd0;
  logic [31:0] reg1 = 32'd0;
  logic [4:0]  waddr = 5'd0;
  logic        we = 1'b0;
  logic [31:0] wdata, hi, lo;
  logic [4:0]  waddr_o;
  logic        we_o, stallreq;

  always #5 clk = ~clk;

  ex u_dut (
    .clk(clk), .rst(rst), .stall(stall), .aluop(aluop), .alusel(alusel),
    .reg0(reg0), .reg1(reg1), .waddr(waddr), .we(we), .wdata(wdata),
    .waddr_o(waddr_o), .we_o(we_o), .stallreq(stallreq), .hi(hi), .lo(lo)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  logic [7:0] comb_ops [17] = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_SLL, OP_SRL,
    OP_SRA, OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU, OP_MFHI, OP_MFLO, OP_MTHI,
    OP_MTLO, OP_MULT, OP_MULTU};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] sel_of(input logic [7:0] op);
    case (op)
      OP_OR, OP_AND, OP_XOR, OP_NOR:        return 3'd1;
      OP_SLL, OP_SRL, OP_SRA:               return 3'd2;
      OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU:    return 3'd3;
      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO:   return 3'd4;
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU:   return 3'd5;
      default:                              return 3'($urandom_range(0, 7));
    endcase
  endfunction

  function automatic bit is_known(input logic [7:0] op);
    foreach (comb_ops[i]) if (comb_ops[i] == op) return 1'b1;
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic bit writes_gpr(input logic [7:0] op);
    return is_known(op) && !(op inside {OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO,
                                        OP_DIV, OP_DIVU});
  endfunction

  // Reference result from the arithmetic meaning of each operation.
  function automatic logic [31:0] ref_wdata(input logic [7:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (op)
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLL:  return 32'(64'(a) * (64'd1 << sh));
      OP_SRL:  return a / (32'd1 << sh);
      OP_SRA:  return 32'(sa >>> sh);
      OP_ADDU: return 32'(64'(a) + 64'(b));
      OP_SUBU: return 32'(64'(a) - 64'(b));
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_MFHI: return m_hi;
      OP_MFLO: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Caller is positioned just after a falling edge.
  task automatic apply_comb(input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic st);
    logic [31:0] exp_w;
    longint      sp;
    logic [63:0] up;
    aluop = op; alusel = sel_of(op); reg0 = a; reg1 = b; stall = st;
    waddr = 5'($urandom); we = 1'($urandom);
    #1;
    exp_w = ref_wdata(op, a, b);
    if (writes_gpr(op) || !is_known(op)) check("wdata", wdata, exp_w);
    check("we_o", 32'(we_o), 32'(we & writes_gpr(op)));
    check("waddr_o", 32'(waddr_o), 32'(waddr));
    check("stallreq_comb", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    if (!st) begin
      case (op)
        OP_MULT: begin
          sp = longint'($signed(a)) * longint'($signed(b));
          {m_hi, m_lo} = 64'(sp);
        end
        OP_MULTU: begin
          up = 64'(a) * 64'(b);
          {m_hi, m_lo} = up;
        end
        OP_MTHI: m_hi = a;
        OP_MTLO: m_lo = a;
        default: ;
      endcase
    end
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    @(negedge clk);
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int nstall);
    int          cnt;
    longint      sa, sb;
    logic [31:0] q, r;
    aluop = sgn ? OP_DIV : OP_DIVU; alusel = 3'd5; reg0 = a; reg1 = b;
    stall = 1'b0; waddr = 5'($urandom); we = 1'b1;
    #1;
    check("div_we_o", 32'(we_o), 32'd0);
    cnt = 0;
    while (stallreq === 1'b1 && cnt < 40) begin
      cnt++;
      @(posedge clk); @(negedge clk);
    end
    check("div_latency", 32'(cnt), (b == 32'd0) ? 32'd1 : 32'd33);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      q = 32'(sa / sb); r = 32'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
    for (int i = 0; i < nstall; i++) begin
      stall = 1'b1;
      @(posedge clk); #1;
      check("done_hold_stallreq", 32'(stallreq), 32'd0);
      check("done_hold_hi", hi, m_hi);
      check("done_hold_lo", lo, m_lo);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    check("done_stallreq", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    m_hi = r; m_lo = q;
    check("div_hi", hi, m_hi);
    check("div_lo", lo, m_lo);
    @(negedge clk);
    aluop = OP_NOP; alusel = 3'd0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op;
    // Reset: registers cleared, combinational path live, no stall request.
    aluop = OP_OR; alusel = 3'd1; reg0 = 32'h0F0F_0000; reg1 = 32'h0000_00F0;
    #2;
    check("rst_wdata", wdata, 32'h0F0F_00F0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    aluop = OP_DIV; alusel = 3'd5; reg1 = 32'd3;
    #1;
    check("rst_stallreq", 32'(stallreq), 32'd0);
    @(negedge clk); @(negedge clk);
    aluop = OP_NOP; alusel = 3'd0;
    rst = 1'b0;
    @(negedge clk);

    // Directed divider and multiplier cases.
    run_div(1'b0, 32'd100, 32'd7, 0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(1'b1, 32'd5, 32'd0, 0);
    run_div(1'b0, 32'd9, 32'd2, 3);
    apply_comb(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
    apply_comb(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    aluop = OP_MFHI; alusel = 3'd4; we = 1'b1; waddr = 5'd3;
    #1;
    check("mfhi_wdata", wdata, m_hi);
    check("mfhi_we_o", 32'(we_o), 32'd1);
    check("mfhi_waddr_o", 32'(waddr_o), 32'd3);
    @(negedge clk);
    apply_comb(OP_NOP, $urandom, $urandom, 1'b0);

    // Reset during BUSY abandons the divide and clears HI/LO at once.
    apply_comb(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    apply_comb(OP_MTLO, 32'h9ABC_DEF0, 32'd0, 1'b0);
    aluop = OP_DIV; alusel = 3'd5; reg0 = 32'd1000; reg1 = 32'hFFFF_FFFD;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    check("midrst_stallreq", 32'(stallreq), 32'd0);
    check("midrst_hi", hi, m_hi);
    check("midrst_lo", lo, m_lo);
    @(negedge clk);
    rst = 1'b0;
    run_div(1'b1, 32'd1000, 32'hFFFF_FFFD, 0);

    // Randomised mix of every operation class.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 8) begin
        run_div(1'($urandom), rnd32(), ($urandom_range(0, 5) == 0) ? 32'd0 : rnd32(),
                int'($urandom_range(0, 3)));
      end else if ($urandom_range(0, 19) == 0) begin
        do op = 8'($urandom); while (is_known(op));
        apply_comb(op, $urandom, $urandom, 1'($urandom_range(0, 4) == 0));
      end else begin
        op = comb_ops[$urandom_range(0, 16)];
        apply_comb(op, rnd32(), rnd32(), 1'($urandom_range(0, 4) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
